// File: rtl/nn_pkg.sv
// Shared types and defaults for the neural-network layer plumbing.
package nn_pkg;

  // Serializer FSM state encoding.
  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Default width of one neuron output (two's complement).
  localparam int DEFAULT_DATA_WIDTH = 16;

endpackage

// File: rtl/layer_out_serializer_argmax_tracker.sv
// argmax_tracker: running signed maximum over one streamed layer vector.
// Reports the index of the largest element one cycle after the last beat.
// Ties keep the lower index because replacement uses a strict greater-than.
module argmax_tracker #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat_valid,
  input  logic                  first,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [IDX_WIDTH-1:0]  index,
  output logic [IDX_WIDTH-1:0]  argmax_idx,
  output logic                  argmax_valid
);

  logic signed [DATA_WIDTH-1:0] max_val;
  logic [IDX_WIDTH-1:0]         max_idx;
  logic                         take;

  // Element 0 always seeds the maximum; later elements must strictly exceed it.
  assign take = first | ($signed(data) > max_val);

  // Running maximum update and one-cycle result pulse after the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_val      <= '0;
      max_idx      <= '0;
      argmax_idx   <= '0;
      argmax_valid <= 1'b0;
    end else begin
      argmax_valid <= 1'b0;
      if (beat_valid) begin
        if (take) begin
          max_val <= $signed(data);
          max_idx <= index;
        end
        if (last) begin
          argmax_valid <= 1'b1;
          argmax_idx   <= take ? index : max_idx;
        end
      end
    end
  end

endmodule

// File: rtl/layer_out_serializer.sv
// layer_out_serializer: latches one layer's parallel neuron outputs and streams
// them neuron 0 first as a valid/ready beat stream.
// Optional output-index tracker: define LAYER_OUT_SERIALIZER_ARGMAX_EN.
//
// state  | meaning
// IDLE   | waiting for all neurons to pulse valid together
// STREAM | presenting held[idx]; advances on each accepted beat
module layer_out_serializer
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_NEURONS-1:0]            in_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic                              error,
  output logic [IDX_WIDTH-1:0]              argmax_idx,
  output logic                              argmax_valid
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

  state_t                state;
  state_t                state_nxt;
  logic [IDX_WIDTH-1:0]  idx;
  logic [DATA_WIDTH-1:0] held [NUM_NEURONS];
  logic                  capture;
  logic                  partial;
  logic                  load;
  logic                  advance;
  logic                  drop;

  // A layer result is only trusted when every neuron pulses together.
  assign capture = &in_valid;
  assign partial = (|in_valid) & ~capture;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and stream outputs; a capture only reloads when it coincides
  // with the final accepted beat, otherwise it is an overrun and is dropped.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    drop      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    case (state)
      IDLE: begin
        if (capture) begin
          load      = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = held[idx];
        out_last  = (idx == LAST_IDX);
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            if (capture) begin
              load = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
        if (capture && !(out_ready && (idx == LAST_IDX))) begin
          drop = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Holding register, beat index and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      error <= 1'b0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        held[n] <= '0;
      end
    end else begin
      if (load) begin
        idx <= '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
          held[n] <= in_data[n*DATA_WIDTH +: DATA_WIDTH];
        end
      end else if (advance) begin
        idx <= idx + 1'b1;
      end
      if (partial || drop) begin
        error <= 1'b1;
      end
    end
  end

`ifdef LAYER_OUT_SERIALIZER_ARGMAX_EN
  logic xfer;
  assign xfer = out_valid & out_ready;

  argmax_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_argmax (
    .clk          (clk),
    .rst          (rst),
    .beat_valid   (xfer),
    .first        (idx == '0),
    .last         (out_last),
    .data         (out_data),
    .index        (idx),
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid)
  );
`else
  assign argmax_idx   = '0;
  assign argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// Self-checking bench for layer_out_serializer with NUM_NEURONS=4, DATA_WIDTH=16.
// Argmax expectations follow LAYER_OUT_SERIALIZER_ARGMAX_EN.
module tb_layer_out_serializer;

  localparam int NN = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NN*DW-1:0] in_data;
  logic [NN-1:0] in_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          error;
  logic [IW-1:0] argmax_idx;
  logic          argmax_valid;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  layer_out_serializer #(
    .NUM_NEURONS (NN),
    .DATA_WIDTH  (DW),
    .IDX_WIDTH   (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .error        (error),
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid)
  );

  typedef struct {
    logic [NN-1:0][DW-1:0] v;
    int                    stall_at;
    int                    stall_len;
    logic [IW-1:0]         exp_am;
  } vec_t;

  vec_t tbl [5];

`ifdef LAYER_OUT_SERIALIZER_ARGMAX_EN
  localparam bit AM_ON = 1'b1;
`else
  localparam bit AM_ON = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: first index holding the largest signed value.
  function automatic logic [IW-1:0] ref_argmax(input logic [NN-1:0][DW-1:0] v);
    int best = 0;
    for (int i = 1; i < NN; i++) begin
      if ($signed(v[i]) > $signed(v[best])) best = i;
    end
    return IW'(best);
  endfunction

  // Capture v, then consume its beats with optional stall or random ready.
  task automatic stream_vec(input logic [NN-1:0][DW-1:0] v, input int stall_at,
                            input int stall_len, input bit rnd_ready,
                            input logic [IW-1:0] exp_am, input string tag);
    int beat = 0;
    int stall = stall_len;
    bit rdy;
    bit done = 1'b0;
    in_data   = v;
    in_valid  = '1;
    out_ready = 1'b1;
    tick();
    in_valid = '0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (beat == stall_at && stall > 0) begin
        rdy = 1'b0;
        stall--;
      end else if (rnd_ready) begin
        rdy = ($urandom_range(0, 2) != 0);
      end else begin
        rdy = 1'b1;
      end
      out_ready = rdy;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, 32'(out_data), 32'(v[beat]));
      chk({tag, "_last"}, 32'(out_last), 32'(beat == NN - 1));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_amv_mid"}, 32'(argmax_valid), 32'd0);
      if (rdy) beat++;
      tick();
      if (beat == NN) done = 1'b1;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    out_ready = 1'b1;
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_amv"}, 32'(argmax_valid), 32'(AM_ON));
    chk({tag, "_am_idx"}, 32'(argmax_idx), AM_ON ? 32'(exp_am) : 32'd0);
    chk({tag, "_err"}, 32'(error), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [NN-1:0][DW-1:0] va, vb, vc, vr;

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b1;

    tbl[0] = '{{16'd4, 16'd3, 16'd2, 16'd1}, -1, 0, 2'd3};
    tbl[1] = '{{16'd4, 16'd3, 16'd2, 16'd1}, 1, 3, 2'd3};
    tbl[2] = '{{16'hFFFF, 16'd7, 16'd7, 16'hFFFB}, -1, 0, 2'd1};
    tbl[3] = '{{16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFD}, 2, 2, 2'd0};
    tbl[4] = '{{16'hFFFF, 16'd0, 16'h7FFF, 16'h8000}, 3, 1, 2'd1};

    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_am_idx", 32'(argmax_idx), 32'd0);
    chk("rst_amv", 32'(argmax_valid), 32'd0);

    for (int t = 0; t < 5; t++) begin
      stream_vec(tbl[t].v, tbl[t].stall_at, tbl[t].stall_len, 1'b0, tbl[t].exp_am,
                 $sformatf("tbl%0d", t));
    end

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NN; i++) vr[i] = DW'($urandom_range(0, 7) * 16'h2401);
      stream_vec(vr, -1, 0, 1'b1, ref_argmax(vr), $sformatf("rnd%0d", r));
    end

    // Back-to-back: second capture on the last transfer, no bubble.
    va = {16'd4, 16'd3, 16'd2, 16'd1};
    vb = {16'd40, 16'd30, 16'd20, 16'd10};
    in_data = va; in_valid = '1; out_ready = 1'b1;
    tick();
    in_valid = '0;
    for (int b = 0; b < NN; b++) begin
      chk("b2b_a_data", 32'(out_data), 32'(va[b]));
      if (b == NN - 1) begin
        in_data  = vb;
        in_valid = '1;
      end
      tick();
    end
    in_valid = '0;
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_b0", 32'(out_data), 32'(vb[0]));
    chk("b2b_err", 32'(error), 32'd0);
    chk("b2b_amv_a", 32'(argmax_valid), 32'(AM_ON));
    chk("b2b_am_a", 32'(argmax_idx), AM_ON ? 32'd3 : 32'd0);
    for (int b = 1; b < NN; b++) begin
      tick();
      chk("b2b_b_data", 32'(out_data), 32'(vb[b]));
    end
    tick();
    chk("b2b_end_valid", 32'(out_valid), 32'd0);
    chk("b2b_amv_b", 32'(argmax_valid), 32'(AM_ON));
    chk("b2b_am_b", 32'(argmax_idx), AM_ON ? 32'd3 : 32'd0);

    // Overrun: capture during beat 1 is dropped, stream continues.
    vc = {16'd99, 16'd98, 16'd97, 16'd96};
    in_data = va; in_valid = '1;
    tick();
    in_valid = '0;
    tick();
    chk("ovr_b1", 32'(out_data), 32'(va[1]));
    in_data = vc; in_valid = '1;
    tick();
    in_valid = '0;
    chk("ovr_b2", 32'(out_data), 32'(va[2]));
    chk("ovr_err", 32'(error), 32'd1);
    tick();
    chk("ovr_b3", 32'(out_data), 32'(va[3]));
    chk("ovr_last", 32'(out_last), 32'd1);
    tick();
    chk("ovr_idle", 32'(out_valid), 32'd0);
    tick();
    chk("ovr_no_restream", 32'(out_valid), 32'd0);
    chk("ovr_err_sticky", 32'(error), 32'd1);
    do_reset();
    chk("ovr_err_cleared", 32'(error), 32'd0);

    // Partial valid pulse.
    in_data = va; in_valid = 4'b0101;
    tick();
    in_valid = '0;
    chk("part_valid", 32'(out_valid), 32'd0);
    chk("part_err", 32'(error), 32'd1);
    tick();
    chk("part_still_idle", 32'(out_valid), 32'd0);
    do_reset();
    chk("part_err_cleared", 32'(error), 32'd0);

    // Reset mid-stream, then a fresh stream starts at element 0.
    in_data = va; in_valid = '1;
    tick();
    in_valid = '0;
    tick();
    tick();
    chk("rmid_b2", 32'(out_data), 32'(va[2]));
    rst = 1'b1;
    tick();
    chk("rmid_valid", 32'(out_valid), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    tick();
    stream_vec(va, -1, 0, 1'b0, 2'd3, "rmid_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_out_serializer.md
# layer_out_serializer

Collects the parallel outputs of one layer of neurons and streams them one value per cycle into the next layer's shared input bus (data + valid), with neuron 0 first. It sits directly downstream of a layer of neuron instances: all neurons in a layer assert their output-valid pulse in the same cycle. When the output-index tracker is compiled in, the same block on the final layer also produces the classification result as the index of the largest output.

## Interface
Parameters:
- NUM_NEURONS, 30, neurons in the source layer (≥2).
- DATA_WIDTH, 16, width of one neuron output (two's complement).
- IDX_WIDTH, $clog2(NUM_NEURONS), index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_NEURONS*DATA_WIDTH  neuron n's output at bits [n*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  NUM_NEURONS  per-neuron output-valid pulse.
- out_data  out  DATA_WIDTH  current streamed value.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts a beat; a transfer happens when out_valid & out_ready.
- out_last  out  1  high with the beat for neuron NUM_NEURONS-1.
- busy  out  1  high while the block is in STREAM.
- error  out  1  sticky error flag; cleared only by rst.
- argmax_idx  out  IDX_WIDTH  index of the largest output (ARGMAX_EN only).
- argmax_valid  out  1  one-cycle pulse when argmax_idx is updated (ARGMAX_EN only).

## Operation
- Capture condition: &in_valid. On capture, the full in_data vector is latched into the holding register and the beat index is reset to 0.
- A partial pulse (|in_valid & ~&in_valid) captures nothing and sets error.
- FSM states:
  - IDLE: when the capture condition holds → STREAM.
  - STREAM: out_valid=1, out_data = held[idx]. On each transfer, idx increments.
  - Transfer with idx==NUM_NEURONS-1 → IDLE, unless a capture happens in the same cycle, in which case the block reloads and stays in STREAM with idx=0.
- Capture while in STREAM without a simultaneous last transfer: the new vector is dropped, error is set, and the current stream continues unaffected.
- out_data is held stable while out_valid & ~out_ready.
- Reset values: state IDLE, idx 0, out_valid 0, out_last 0, busy 0, error 0, out_data 0, argmax_idx 0, argmax_valid 0.
- rst in mid-stream aborts the stream; out_valid drops on the next edge and the held data is discarded.

## Timing
- Capture at clock edge T → out_valid=1 with element 0 at T+1.
- With out_ready held high, NUM_NEURONS consecutive beats follow, T+1 … T+NUM_NEURONS, with out_last on the final beat.
- Back-to-back vectors: a capture coincident with the last transfer gives zero bubble; element 0 of the new vector appears the next cycle.
- out_ready low stalls the stream indefinitely, with no data loss within the current vector.
- argmax_valid pulses exactly one cycle after the last transfer. argmax_idx updates on that same edge and then holds until the next pulse.

## Configuration
- Macro: LAYER_OUT_SERIALIZER_ARGMAX_EN.
- Defined:
  - A running maximum is updated on every transfer using a signed compare on DATA_WIDTH bits.
  - On ties the lower index is kept (strict > for replacement).
  - The maximum is reinitialised from element 0's transfer.
  - argmax_idx and argmax_valid are driven as described above.
- Undefined: no compare logic is built; argmax_idx and argmax_valid are tied to 0.

## Structure
- Shared package nn_pkg: state enum typedef (IDLE, STREAM) and the default DATA_WIDTH constant.
- Sub-module argmax_tracker:
  - Inputs: clk, rst, beat valid, first flag, last flag, data, index.
  - Outputs: argmax_idx, argmax_valid.
  - Instantiated only under LAYER_OUT_SERIALIZER_ARGMAX_EN.

## Test plan
- Single vector, NUM_NEURONS=4, in_data={4,3,2,1} as signed elements n=3..0, out_ready=1 → beats 1,2,3,4 on cycles T+1..T+4; out_last only on the beat with 4; busy falls after T+4.
- Backpressure: same vector with out_ready low for 3 cycles at beat 2 → out_data stays at 2 throughout the stall; beat order is unchanged; exactly 4 transfers total.
- Back-to-back: second capture coincident with the last transfer → no idle cycle; element 0 of the second vector follows immediately; error stays 0.
- Overrun and partial valid: capture during beat 1 → first stream completes intact and error=1. Separately, in_valid=4'b0101 → no stream and error=1. rst clears error to 0.
- Argmax (macro defined): vector {-5,7,7,-1} as elements 0..3 → argmax_idx=1 with argmax_valid pulsing one cycle after the last beat. Vector of all -3 → argmax_idx=0.
- Reset mid-stream: rst asserted at beat 2 → out_valid=0 on the next edge; a new capture afterwards streams from element 0.
